// File: rtl/hazard_sequencer.sv
// Central sequencer for the 5-stage MIPS pipeline: stage enables/clears, RAW stall,
// branch/jump flush, single-step gating and LCD statistics counters.
module hazard_sequencer #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4,
    parameter int WB_HAZARD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             exe_wen,
    input  logic [4:0]       exe_waddr,
    input  logic             mem_wen,
    input  logic [4:0]       mem_waddr,
    input  logic             wb_wen,
    input  logic [4:0]       wb_waddr,
    input  logic             mem_valid,
    input  logic             mem_redirect,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             pc_redirect,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_err
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SR_W = ($clog2(MAX_STALL + 1) > 3) ? $clog2(MAX_STALL + 1) : 3;
    localparam logic [SR_W-1:0]  SR_MAX   = '1;
    localparam logic [SR_W-1:0]  SR_LIMIT = SR_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // A source only conflicts if it is actually read, is not $0, and the writer commits.
    function automatic logic srcHit(input logic [4:0] src, input logic used,
                                    input logic wen, input logic [4:0] waddr);
        return used && (src != 5'd0) && wen && (src == waddr);
    endfunction

    logic             w_adv;
    logic             w_redir;
    logic             w_hzd;
    logic             w_exeHit;
    logic             w_memHit;
    logic             w_wbHit;
    state_t           w_class;
    state_t           r_state;
    logic [SR_W-1:0]  w_stallRunNext;
    logic [SR_W-1:0]  r_stallRun;
    logic [CNT_W-1:0] r_cycleCnt;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;
    logic             r_stallErr;

    assign w_adv    = !step_mode || step_req;
    assign w_redir  = mem_valid && mem_redirect;
    assign w_exeHit = srcHit(id_rs, id_rs_used, exe_wen, exe_waddr) ||
                      srcHit(id_rt, id_rt_used, exe_wen, exe_waddr);
    assign w_memHit = srcHit(id_rs, id_rs_used, mem_wen, mem_waddr) ||
                      srcHit(id_rt, id_rt_used, mem_wen, mem_waddr);
    assign w_wbHit  = (WB_HAZARD != 0) &&
                      (srcHit(id_rs, id_rs_used, wb_wen, wb_waddr) ||
                       srcHit(id_rt, id_rt_used, wb_wen, wb_waddr));
    assign w_hzd    = id_valid && (w_exeHit || w_memHit || w_wbHit);

    always_comb begin
        w_class     = RUN;
        if_en       = 1'b1;
        id_en       = 1'b1;
        exe_en      = 1'b1;
        mem_en      = 1'b1;
        wb_en       = 1'b1;
        id_rst      = 1'b0;
        exe_rst     = 1'b0;
        mem_rst     = 1'b0;
        wb_rst      = 1'b0;
        pc_redirect = 1'b0;
        if (rst) begin
            {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
            {id_rst, exe_rst, mem_rst, wb_rst}    = 4'b1111;
        end else if (!w_adv) begin
            w_class = HOLD;
            {if_en, id_en, exe_en, mem_en, wb_en} = 5'b00000;
        end else if (w_redir) begin
            // The branch itself retires through WB; only the three younger slots are squashed.
            w_class     = FLUSH;
            id_rst      = 1'b1;
            exe_rst     = 1'b1;
            mem_rst     = 1'b1;
            pc_redirect = 1'b1;
        end else if (w_hzd) begin
            w_class = STALL;
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end
    end

    always_comb begin
        w_stallRunNext = '0;
        case (w_class)
            STALL:   w_stallRunNext = (r_stallRun == SR_MAX) ? r_stallRun : r_stallRun + SR_W'(1);
            HOLD:    w_stallRunNext = r_stallRun;
            default: w_stallRunNext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_stallRun <= '0;
            r_cycleCnt <= '0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
            r_stallErr <= 1'b0;
        end else begin
            r_state    <= w_class;
            r_stallRun <= w_stallRunNext;
            if (w_adv && (r_cycleCnt != CNT_MAX))
                r_cycleCnt <= r_cycleCnt + CNT_W'(1);
            if ((w_class == STALL) && (r_stallCnt != CNT_MAX))
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if ((w_class == FLUSH) && (r_flushCnt != CNT_MAX))
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            if ((w_class == STALL) && (w_stallRunNext >= SR_LIMIT))
                r_stallErr <= 1'b1;
        end
    end

    assign state     = r_state;
    assign cycle_cnt = r_cycleCnt;
    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
    assign stall_err = r_stallErr;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed vector bench for hazard_sequencer; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_hazard_sequencer;

    typedef struct packed {
        logic [1:0] step;
        logic       idValid;
        logic [4:0] rs;
        logic       rsUsed;
        logic [4:0] rt;
        logic       rtUsed;
        logic       exeWen;
        logic [4:0] exeWaddr;
        logic       memWen;
        logic [4:0] memWaddr;
        logic       wbWen;
        logic [4:0] wbWaddr;
        logic [1:0] memRedir;
    } stim_t;

    typedef struct packed {
        stim_t      stim;
        logic [9:0] expCtrl;
        logic [1:0] expState;
    } vec_t;

    // Control bit order: {if,id,exe,mem,wb enables, id,exe,mem,wb clears, pc_redirect}
    localparam logic [9:0] CTRL_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] CTRL_HOLD  = 10'b00000_0000_0;
    localparam logic [9:0] CTRL_FLUSH = 10'b11111_1110_1;
    localparam logic [9:0] CTRL_STALL = 10'b00111_0100_0;
    localparam logic [9:0] CTRL_RST   = 10'b00000_1111_0;
    localparam logic [1:0] S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_HOLD = 2'd3;
    localparam int NVEC = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, step_mode, step_req, id_valid, id_rs_used, id_rt_used;
    logic exe_wen, mem_wen, wb_wen, mem_valid, mem_redirect;
    logic [4:0] id_rs, id_rt, exe_waddr, mem_waddr, wb_waddr;
    logic if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst, mem_rst, wb_rst, pc_redirect;
    logic [1:0] state;
    logic [15:0] cycle_cnt, stall_cnt, flush_cnt;
    logic stall_err;
    logic [9:0] satCtrl;
    logic [1:0] satState;
    logic [3:0] satCycle, satStall, satFlush;
    logic satErr;

    int checks = 0;
    int errors = 0;
    int expCycle, expStall, expFlush;
    logic expErr;
    vec_t vecs[NVEC];

    hazard_sequencer dut (
        .clk(clk), .rst(rst), .step_mode(step_mode), .step_req(step_req),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .mem_valid(mem_valid), .mem_redirect(mem_redirect),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst), .wb_rst(wb_rst),
        .pc_redirect(pc_redirect), .state(state), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_err(stall_err)
    );

    hazard_sequencer #(.CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .step_mode(step_mode), .step_req(step_req),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .exe_wen(exe_wen), .exe_waddr(exe_waddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .wb_wen(wb_wen), .wb_waddr(wb_waddr), .mem_valid(mem_valid), .mem_redirect(mem_redirect),
        .if_en(satCtrl[9]), .id_en(satCtrl[8]), .exe_en(satCtrl[7]), .mem_en(satCtrl[6]),
        .wb_en(satCtrl[5]), .id_rst(satCtrl[4]), .exe_rst(satCtrl[3]), .mem_rst(satCtrl[2]),
        .wb_rst(satCtrl[1]), .pc_redirect(satCtrl[0]), .state(satState), .cycle_cnt(satCycle),
        .stall_cnt(satStall), .flush_cnt(satFlush), .stall_err(satErr)
    );

    function automatic stim_t mkStim(input logic [1:0] step, input logic idV,
                                     input logic [4:0] rs, input logic rsU,
                                     input logic [4:0] rt, input logic rtU,
                                     input logic exeW, input logic [4:0] exeA,
                                     input logic memW, input logic [4:0] memA,
                                     input logic wbW, input logic [4:0] wbA,
                                     input logic [1:0] mr);
        stim_t s;
        s.step = step;     s.idValid = idV;
        s.rs = rs;         s.rsUsed = rsU;
        s.rt = rt;         s.rtUsed = rtU;
        s.exeWen = exeW;   s.exeWaddr = exeA;
        s.memWen = memW;   s.memWaddr = memA;
        s.wbWen = wbW;     s.wbWaddr = wbA;
        s.memRedir = mr;
        return s;
    endfunction

    function automatic logic [9:0] ctrlNow();
        return {if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst, mem_rst, wb_rst, pc_redirect};
    endfunction

    function automatic int satOf(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic applyStimulus(input stim_t s);
        {step_mode, step_req} = s.step;
        id_valid   = s.idValid;
        id_rs      = s.rs;
        id_rs_used = s.rsUsed;
        id_rt      = s.rt;
        id_rt_used = s.rtUsed;
        exe_wen    = s.exeWen;
        exe_waddr  = s.exeWaddr;
        mem_wen    = s.memWen;
        mem_waddr  = s.memWaddr;
        wb_wen     = s.wbWen;
        wb_waddr   = s.wbWaddr;
        {mem_valid, mem_redirect} = s.memRedir;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // One cycle: drive, check combinational control, clock, check registered results.
    task automatic stepCheck(input stim_t s, input logic [9:0] ctrl, input logic [1:0] st,
                             input string tag);
        applyStimulus(s);
        #2;
        checkOutput({tag, " ctrl"}, 32'(ctrlNow()), 32'(ctrl));
        checkOutput({tag, " satCtrl"}, 32'(satCtrl), 32'(ctrl));
        if (st != S_HOLD) expCycle++;
        if (st == S_STALL) expStall++;
        if (st == S_FLUSH) expFlush++;
        @(posedge clk);
        #1;
        checkOutput({tag, " state"}, 32'(state), 32'(st));
        checkOutput({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'(expCycle));
        checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), 32'(expStall));
        checkOutput({tag, " flush_cnt"}, 32'(flush_cnt), 32'(expFlush));
        checkOutput({tag, " stall_err"}, 32'(stall_err), 32'(expErr));
        checkOutput({tag, " satCycle"}, 32'(satCycle), 32'(satOf(expCycle)));
    endtask

    task automatic doReset(input stim_t s, input string tag);
        rst = 1'b1;
        applyStimulus(s);
        #2;
        checkOutput({tag, " rst ctrl"}, 32'(ctrlNow()), 32'(CTRL_RST));
        @(posedge clk);
        #1;
        expCycle = 0; expStall = 0; expFlush = 0; expErr = 1'b0;
        checkOutput({tag, " rst state"}, 32'(state), 32'(S_RUN));
        checkOutput({tag, " rst cycle_cnt"}, 32'(cycle_cnt), 0);
        checkOutput({tag, " rst stall_cnt"}, 32'(stall_cnt), 0);
        checkOutput({tag, " rst flush_cnt"}, 32'(flush_cnt), 0);
        checkOutput({tag, " rst stall_err"}, 32'(stall_err), 0);
        checkOutput({tag, " rst satCycle"}, 32'(satCycle), 0);
        rst = 1'b0;
    endtask

    initial begin
        stim_t idle, haz, holdHaz;
        idle    = mkStim(2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00);
        haz     = mkStim(2'b00, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00);
        holdHaz = haz;
        holdHaz.step = 2'b10;

        vecs[0]  = '{idle, CTRL_RUN, S_RUN};
        vecs[1]  = '{haz, CTRL_STALL, S_STALL};
        vecs[2]  = '{mkStim(2'b00, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 2'b00), CTRL_STALL, S_STALL};
        vecs[3]  = '{mkStim(2'b00, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 2'b00), CTRL_RUN, S_RUN};
        vecs[4]  = '{mkStim(2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 2'b00), CTRL_RUN, S_RUN};
        vecs[5]  = '{mkStim(2'b00, 1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00), CTRL_RUN, S_RUN};
        vecs[6]  = '{mkStim(2'b00, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 2'b00), CTRL_STALL, S_STALL};
        vecs[7]  = '{mkStim(2'b00, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 2'b00), CTRL_RUN, S_RUN};
        vecs[8]  = '{mkStim(2'b00, 1'b0, 5'd1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 2'b00), CTRL_RUN, S_RUN};
        vecs[9]  = '{mkStim(2'b00, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 2'b11), CTRL_FLUSH, S_FLUSH};
        vecs[10] = '{mkStim(2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b11), CTRL_FLUSH, S_FLUSH};
        vecs[11] = '{mkStim(2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b01), CTRL_RUN, S_RUN};
        vecs[12] = '{mkStim(2'b10, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00), CTRL_HOLD, S_HOLD};
        vecs[13] = '{mkStim(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00), CTRL_RUN, S_RUN};
        vecs[14] = '{mkStim(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b11), CTRL_FLUSH, S_FLUSH};
        vecs[15] = '{mkStim(2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b11), CTRL_HOLD, S_HOLD};
        vecs[16] = '{mkStim(2'b01, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00), CTRL_STALL, S_STALL};

        expErr = 1'b0;
        doReset(idle, "init");

        for (int i = 0; i < NVEC; i++)
            stepCheck(vecs[i].stim, vecs[i].expCtrl, vecs[i].expState, $sformatf("vec%0d", i));

        // Single-step: five idle HOLD cycles, one step pulse, then HOLD again.
        for (int i = 0; i < 5; i++)
            stepCheck(mkStim(2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00),
                      CTRL_HOLD, S_HOLD, $sformatf("hold%0d", i));
        stepCheck(mkStim(2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00),
                  CTRL_RUN, S_RUN, "stepPulse");
        stepCheck(mkStim(2'b10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'b00),
                  CTRL_HOLD, S_HOLD, "holdAfter");

        // Stall run is preserved across HOLD: 3 stalls + 2 holds + 1 stall reaches the limit.
        for (int i = 0; i < 3; i++)
            stepCheck(haz, CTRL_STALL, S_STALL, $sformatf("runA%0d", i));
        stepCheck(holdHaz, CTRL_HOLD, S_HOLD, "runHold0");
        stepCheck(holdHaz, CTRL_HOLD, S_HOLD, "runHold1");
        expErr = 1'b1;
        stepCheck(haz, CTRL_STALL, S_STALL, "runB");
        doReset(idle, "afterRun");

        // Continuous hazard: error appears after the 4th stall and is sticky.
        for (int k = 1; k <= 6; k++) begin
            expErr = (k >= 4);
            stepCheck(haz, CTRL_STALL, S_STALL, $sformatf("stall%0d", k));
        end
        stepCheck(idle, CTRL_RUN, S_RUN, "stickyRun");
        stepCheck(haz, CTRL_STALL, S_STALL, "stickyStall");

        // Reset while stalling clears everything, including the sticky error.
        doReset(haz, "midStall");

        for (int i = 0; i < 20; i++)
            stepCheck(idle, CTRL_RUN, S_RUN, $sformatf("sat%0d", i));
        checkOutput("satCycle saturated", 32'(satCycle), 32'd15);
        checkOutput("cycle_cnt 20", 32'(cycle_cnt), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
